// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle between the four requesters and the round-robin arbiter.
// The master side drives requests and data. The slave side (the arbiter)
// drives the grant, select, enable and registered output data.
interface mux4_rr_arbiter_if #(
    parameter int W = 4
);
    logic [3:0]   req;
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic [W-1:0] a2;
    logic [W-1:0] a3;
    logic [3:0]   gnt;
    logic [1:0]   s;
    logic         en;
    logic [W-1:0] f;
    logic         f_valid;

    modport master (
        output req, a0, a1, a2, a3,
        input  gnt, s, en, f, f_valid
    );

    modport slave (
        input  req, a0, a1, a2, a3,
        output gnt, s, en, f, f_valid
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and output sequencer for a shared W-bit bus with four
// requesters. An owner keeps the bus until it drops its request or has held
// it for HOLD_MAX cycles. Ownership then rotates, with the previous owner
// given the lowest priority. The selected input is registered onto f one
// cycle after the cycle in which it was granted.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 4,   // legal range 1..15
    parameter int W        = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    mux4_rr_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD = 4'(HOLD_MAX);

    state_t       state_q, state_d;
    logic [1:0]   owner_q, owner_d;
    logic [3:0]   cnt_q,   cnt_d;
    logic [1:0]   last_q,  last_d;
    logic [3:0]   gnt_q,   gnt_d;
    logic [1:0]   s_q,     s_d;
    logic         en_q,    en_d;
    logic [W-1:0] f_q,     f_d;
    logic         fv_q,    fv_d;

    // The search always starts one place after the "previous owner". When
    // releasing from GRANT, the current owner becomes that previous owner
    // on this same edge, so it is used as the base directly.
    logic [1:0] base_idx;
    logic [1:0] start_idx;
    logic [3:0] rot_req;
    logic [1:0] win_off;
    logic       win_found;
    logic [1:0] winner;
    logic       release_own;
    logic [W-1:0] sel_data;

    assign base_idx  = (state_q == GRANT) ? owner_q : last_q;
    assign start_idx = base_idx + 2'd1;

    // Rotate the request vector so bit 0 is the highest-priority requester.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = bus.req[start_idx + 2'(gi)];
        end
    endgenerate

    // Pick the first active request in rotated order.
    always_comb begin
        win_off = 2'd0;
        if (rot_req[0])      win_off = 2'd0;
        else if (rot_req[1]) win_off = 2'd1;
        else if (rot_req[2]) win_off = 2'd2;
        else if (rot_req[3]) win_off = 2'd3;
    end

    assign win_found   = |rot_req;
    assign winner      = start_idx + win_off;
    assign release_own = (state_q == GRANT) &&
                         (!bus.req[owner_q] || (cnt_q == HOLD));

    // Input mux driven by the registered select code.
    always_comb begin
        case (s_q)
            2'd0:    sel_data = bus.a0;
            2'd1:    sel_data = bus.a1;
            2'd2:    sel_data = bus.a2;
            default: sel_data = bus.a3;
        endcase
    end

    // Next-state for ownership, hold counter, grant outputs and datapath.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        en_d    = en_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    owner_d = winner;
                    cnt_d   = 4'd1;
                    gnt_d   = 4'b0001 << winner;
                    s_d     = winner;
                    en_d    = 1'b1;
                end else begin
                    gnt_d = 4'b0000;
                    en_d  = 1'b0;
                end
            end
            default: begin
                if (release_own) begin
                    last_d = owner_q;
                    if (win_found) begin
                        // Back-to-back handover; en stays high.
                        owner_d = winner;
                        cnt_d   = 4'd1;
                        gnt_d   = 4'b0001 << winner;
                        s_d     = winner;
                        en_d    = 1'b1;
                    end else begin
                        // s keeps the last owner's code.
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        en_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase

        f_d  = en_q ? sel_data : '0;
        fv_d = en_q;
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            cnt_q   <= 4'd0;
            last_q  <= 2'd3;
            gnt_q   <= 4'b0000;
            s_q     <= 2'd0;
            en_q    <= 1'b0;
            f_q     <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            en_q    <= en_d;
            f_q     <= f_d;
            fv_q    <= fv_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.s       = s_q;
    assign bus.en      = en_q;
    assign bus.f       = f_q;
    assign bus.f_valid = fv_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: two instances (hold limits 4 and 1) share
// the same stimulus and are checked each cycle against a behavioural model
// of the rotation rules.
module tb_mux4_rr_arbiter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   req;
    logic [W-1:0] a [4];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.W(W)) bus4 ();
    mux4_rr_arbiter_if #(.W(W)) bus1 ();

    assign bus4.req = req;
    assign bus4.a0  = a[0];
    assign bus4.a1  = a[1];
    assign bus4.a2  = a[2];
    assign bus4.a3  = a[3];
    assign bus1.req = req;
    assign bus1.a0  = a[0];
    assign bus1.a1  = a[1];
    assign bus1.a2  = a[2];
    assign bus1.a3  = a[3];

    mux4_rr_arbiter #(.HOLD_MAX(4), .W(W)) u_dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus4)
    );

    mux4_rr_arbiter #(.HOLD_MAX(1), .W(W)) u_dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    // Reference model: index 0 models HOLD_MAX=4, index 1 models HOLD_MAX=1.
    int hold    [2] = '{4, 1};
    int m_owner [2];   // -1 when nobody owns the bus
    int m_cnt   [2];
    int m_last  [2];
    int m_gnt   [2];
    int m_s     [2];
    int m_en    [2];
    int m_f     [2];
    int m_fv    [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_cnt[k]   = 0;
            m_last[k]  = 3;
            m_gnt[k]   = 0;
            m_s[k]     = 0;
            m_en[k]    = 0;
            m_f[k]     = 0;
            m_fv[k]    = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int nf;
            int w;
            nf = (m_en[k] != 0) ? int'(a[m_s[k]]) : 0;
            m_fv[k] = m_en[k];
            m_f[k]  = nf;
            if (m_owner[k] >= 0 && req[m_owner[k]] && m_cnt[k] < hold[k]) begin
                m_cnt[k] = m_cnt[k] + 1;
            end else begin
                if (m_owner[k] >= 0) m_last[k] = m_owner[k];
                w = -1;
                for (int i = 1; i <= 4; i++) begin
                    if (w < 0 && req[(m_last[k] + i) % 4]) w = (m_last[k] + i) % 4;
                end
                if (w >= 0) begin
                    m_owner[k] = w;
                    m_cnt[k]   = 1;
                    m_gnt[k]   = 1 << w;
                    m_s[k]     = w;
                    m_en[k]    = 1;
                end else begin
                    m_owner[k] = -1;
                    m_gnt[k]   = 0;
                    m_en[k]    = 0;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic check_all(string step);
        chk($sformatf("%s h4 gnt", step), 32'(bus4.gnt),     32'(m_gnt[0]));
        chk($sformatf("%s h4 s",   step), 32'(bus4.s),       32'(m_s[0]));
        chk($sformatf("%s h4 en",  step), 32'(bus4.en),      32'(m_en[0]));
        chk($sformatf("%s h4 f",   step), 32'(bus4.f),       32'(m_f[0]));
        chk($sformatf("%s h4 fv",  step), 32'(bus4.f_valid), 32'(m_fv[0]));
        chk($sformatf("%s h1 gnt", step), 32'(bus1.gnt),     32'(m_gnt[1]));
        chk($sformatf("%s h1 s",   step), 32'(bus1.s),       32'(m_s[1]));
        chk($sformatf("%s h1 en",  step), 32'(bus1.en),      32'(m_en[1]));
        chk($sformatf("%s h1 f",   step), 32'(bus1.f),       32'(m_f[1]));
        chk($sformatf("%s h1 fv",  step), 32'(bus1.f_valid), 32'(m_fv[1]));
    endtask

    // One clock: inputs already set, model advances on the edge,
    // outputs compared on the falling edge.
    task automatic cyc(string step, int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all(step);
        end
    endtask

    initial begin
        req  = 4'b1111;
        a[0] = 4'h1;
        a[1] = 4'h2;
        a[2] = 4'h4;
        a[3] = 4'h8;
        model_reset();

        // Reset asserted with every requester active.
        #1 rst_n = 1'b0;
        #1 check_all("reset");
        @(negedge clk);
        check_all("reset_hold");
        rst_n = 1'b1;

        // First grant after reset goes to requester 0.
        cyc("post_reset", 1);
        chk("first_gnt", 32'(bus4.gnt), 32'h1);

        // Full contention: rotation 0,1,2,3,0 with hold 4.
        cyc("contention", 19);

        // Sole requester keeps the bus indefinitely.
        req  = 4'b0001;
        a[0] = 4'hA;
        cyc("sole", 12);
        chk("sole_f", 32'(bus4.f), 32'hA);

        // Early drop: requester 2 owns, drops after two cycles.
        req = 4'b1100;
        cyc("drop_a", 2);
        chk("drop_owner", 32'(bus4.gnt), 32'h4);
        req = 4'b1000;
        cyc("drop_b", 1);
        chk("drop_hand", 32'(bus4.gnt), 32'h8);
        chk("drop_en", 32'(bus4.en), 32'h1);

        // Fairness with hold 1: alternating grants.
        req = 4'b1010;
        cyc("fair", 6);

        // Nobody requesting.
        req = 4'b0000;
        cyc("idle", 3);

        // Mid-grant asynchronous reset.
        req = 4'b0100;
        cyc("pre_rst", 2);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        cyc("after_rst", 1);
        chk("after_rst_gnt", 32'(bus4.gnt), 32'h2);

        // Randomized traffic with sticky requests.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            for (int j = 0; j < 4; j++) a[j] = 4'($urandom_range(0, 15));
            cyc("random", 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
